// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared constants for the arithmetic-unit command sequencer.
package alu_seq_pkg;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_TAG_W = 4;
    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] MUL = 2'b10;
    localparam logic [1:0] DIV = 2'b11;
    localparam logic [DEF_WIDTH-1:0] DZ_RESULT = {DEF_WIDTH{1'b1}};
endpackage

// File: rtl/alu_sync_fifo.sv
// alu_sync_fifo: synchronous FIFO with occupancy count; head shown combinationally.
module alu_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        din,
    input  logic                     pop,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];
    // Storage is cleared too so the head reads zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues tagged commands, issues them to the arithmetic unit
// under result-FIFO credits, and collects tagged results.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int TAG_W     = DEF_TAG_W,
    parameter int CMD_DEPTH = 4,
    parameter int RES_DEPTH = 4
) (
    input  logic             Clk,
    input  logic             RST,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [1:0]       cmd_fun,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [1:0]       Arith_FUN,
    output logic             Arith_Enable,
    input  logic [WIDTH-1:0] Arith_OUT,
    input  logic             Carry_OUT,
    input  logic             Arith_Flag,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_carry,
    output logic             res_dz,
    output logic [TAG_W-1:0] res_tag,
    output logic             busy,
    output logic             seq_err
);
    localparam int CW  = 2*WIDTH + 2 + TAG_W;
    localparam int RW  = WIDTH + 2 + TAG_W;
    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RES_DEPTH);
    localparam logic [WIDTH-1:0] DZ = {WIDTH{1'b1}};

    logic [CW-1:0] cmd_head;
    logic [RW-1:0] res_head;
    logic [CAW:0] cmd_count;
    logic [RAW:0] res_count;
    logic [RAW+1:0] credits_used;
    logic cmd_full, cmd_empty, res_full, res_empty, issue;
    logic [WIDTH-1:0] head_a, head_b;
    logic [1:0] head_fun;
    logic [TAG_W-1:0] head_tag, s1_tag, s2_tag;
    logic s1_v, s2_v, s1_dz, s2_dz;

    assign {head_a, head_b, head_fun, head_tag} = cmd_head;
    assign {res_data, res_carry, res_dz, res_tag} = res_head;
    assign cmd_ready = ~cmd_full;
    assign res_valid = ~res_empty;
    // Every issued command owns a result slot until it is popped.
    assign credits_used = (RAW+2)'(res_count) + (RAW+2)'(s1_v) + (RAW+2)'(s2_v);
    assign issue = ~cmd_empty & (credits_used < (RAW+2)'(RES_DEPTH));
    assign busy = (cmd_count != '0) | s1_v | s2_v | (res_count != '0);

    alu_sync_fifo #(.DATA_W(CW), .DEPTH(CMD_DEPTH)) cmd_fifo (
        .clk(Clk), .rst(RST), .push(cmd_valid & cmd_ready),
        .din({cmd_a, cmd_b, cmd_fun, cmd_tag}), .pop(issue), .dout(cmd_head),
        .full(cmd_full), .empty(cmd_empty), .count(cmd_count)
    );

    alu_sync_fifo #(.DATA_W(RW), .DEPTH(RES_DEPTH)) res_fifo (
        .clk(Clk), .rst(RST), .push(s2_v & ~res_full),
        .din({s2_dz ? DZ : Arith_OUT, Carry_OUT, s2_dz, s2_tag}),
        .pop(res_valid & res_ready), .dout(res_head),
        .full(res_full), .empty(res_empty), .count(res_count)
    );

    always_ff @(posedge Clk or posedge RST) begin
        if (RST) begin
            A            <= '0;
            B            <= '0;
            Arith_FUN    <= '0;
            Arith_Enable <= 1'b0;
            s1_v         <= 1'b0;
            s2_v         <= 1'b0;
            s1_dz        <= 1'b0;
            s2_dz        <= 1'b0;
            s1_tag       <= '0;
            s2_tag       <= '0;
            seq_err      <= 1'b0;
        end else begin
            Arith_Enable <= issue;
            s1_v         <= issue;
            s2_v         <= s1_v;
            s2_tag       <= s1_tag;
            s2_dz        <= s1_dz;
            if (issue) begin
                A         <= head_a;
                B         <= head_b;
                Arith_FUN <= head_fun;
                s1_tag    <= head_tag;
                s1_dz     <= (head_fun == DIV) && (head_b == '0);
            end
            if (s2_v && !Arith_Flag) seq_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed bench with a behavioural one-cycle arithmetic unit.
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    logic        Clk = 1'b0;
    logic        RST = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [15:0] cmd_a = '0, cmd_b = '0;
    logic [1:0]  cmd_fun = '0;
    logic [3:0]  cmd_tag = '0;
    logic [15:0] A, B, Arith_OUT;
    logic [1:0]  Arith_FUN;
    logic        Arith_Enable, Carry_OUT, Arith_Flag;
    logic        res_valid, res_ready = 1'b0, res_carry, res_dz, busy, seq_err;
    logic [15:0] res_data;
    logic [3:0]  res_tag;
    bit          flag_kill = 1'b0;

    int checks = 0, errors = 0;
    int n_acc = 0, n_cmds = 0, cyc = 0;
    logic [15:0] s_a [16], s_b [16];
    logic [1:0]  s_fun [16];
    logic [3:0]  s_tag [16];
    logic [15:0] got_d [$];
    logic [3:0]  got_t [$];
    int          got_c [$];

    typedef struct {
        logic [1:0]  fun;
        logic [15:0] a, b;
        logic [3:0]  tag;
        logic [15:0] d;
        logic        c, dz;
    } vec_t;
    vec_t vecs [8];

    alu_cmd_sequencer dut (
        .Clk(Clk), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_fun(cmd_fun), .cmd_tag(cmd_tag),
        .A(A), .B(B), .Arith_FUN(Arith_FUN), .Arith_Enable(Arith_Enable),
        .Arith_OUT(Arith_OUT), .Carry_OUT(Carry_OUT), .Arith_Flag(Arith_Flag),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_carry(res_carry), .res_dz(res_dz), .res_tag(res_tag),
        .busy(busy), .seq_err(seq_err)
    );

    always #5 Clk = ~Clk;

    // Arithmetic unit: registers its result one edge after an enabled cycle.
    always @(posedge Clk or posedge RST) begin
        if (RST) begin
            Arith_OUT  <= '0;
            Carry_OUT  <= 1'b0;
            Arith_Flag <= 1'b0;
        end else begin
            Arith_Flag <= Arith_Enable & ~flag_kill;
            if (Arith_Enable) begin
                case (Arith_FUN)
                    ADD: {Carry_OUT, Arith_OUT} <= {1'b0, A} + {1'b0, B};
                    SUB: {Carry_OUT, Arith_OUT} <= {1'b0, A} - {1'b0, B};
                    MUL: begin
                        Arith_OUT <= 16'(A * B);
                        Carry_OUT <= (32'(A) * 32'(B)) > 32'hFFFF;
                    end
                    default: begin
                        Arith_OUT <= (B == 16'h0) ? 16'h0 : A / B;
                        Carry_OUT <= 1'b0;
                    end
                endcase
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        cmd_valid = n_acc < n_cmds;
        if (n_acc < n_cmds) begin
            cmd_a = s_a[n_acc]; cmd_b = s_b[n_acc];
            cmd_fun = s_fun[n_acc]; cmd_tag = s_tag[n_acc];
        end
    endtask

    task automatic tick();
        bit acc, pop;
        acc = cmd_valid && cmd_ready;
        pop = res_valid && res_ready;
        if (pop) begin
            got_d.push_back(res_data); got_t.push_back(res_tag); got_c.push_back(cyc);
        end
        @(posedge Clk); #1;
        cyc++;
        if (acc) n_acc++;
    endtask

    task automatic start_stream(input int n);
        n_cmds = n; n_acc = 0;
        got_d.delete(); got_t.delete(); got_c.delete();
    endtask

    task automatic apply_vec(input vec_t v, input logic exp_err);
        int lat, en_cnt;
        cmd_a = v.a; cmd_b = v.b; cmd_fun = v.fun; cmd_tag = v.tag;
        cmd_valid = 1'b1;
        chk("cmd_ready_idle", cmd_ready, 1);
        @(posedge Clk); #1;
        cmd_valid = 1'b0;
        lat = 0; en_cnt = 0;
        while (!res_valid && lat < 10) begin
            if (Arith_Enable) en_cnt++;
            @(posedge Clk); #1;
            lat++;
        end
        chk("latency", lat, 3);
        chk("enable_pulses", en_cnt, 1);
        chk("res_data", res_data, v.d);
        chk("res_carry", res_carry, v.c);
        chk("res_dz", res_dz, v.dz);
        chk("res_tag", res_tag, v.tag);
        chk("seq_err", seq_err, exp_err);
        res_ready = 1'b1;
        @(posedge Clk); #1;
        res_ready = 1'b0;
        chk("res_valid_after_pop", res_valid, 0);
        chk("busy_after_pop", busy, 0);
    endtask

    task automatic reset_pulse();
        RST = 1'b1;
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_enable", Arith_Enable, 0);
        chk("rst_A", A, 0);
        chk("rst_B", B, 0);
        chk("rst_fun", Arith_FUN, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_tag", res_tag, 0);
        chk("rst_seq_err", seq_err, 0);
        @(posedge Clk); #1;
        RST = 1'b0;
    endtask

    initial begin
        int seen, guard;
        vecs[0] = '{ADD, 16'hFFFF, 16'h0001, 4'd3, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{SUB, 16'd10,   16'd3,    4'd1, 16'd7,    1'b0, 1'b0};
        vecs[2] = '{MUL, 16'd300,  16'd300,  4'd2, 16'h5F90, 1'b1, 1'b0};
        vecs[3] = '{DIV, 16'd100,  16'd7,    4'd3, 16'd14,   1'b0, 1'b0};
        vecs[4] = '{DIV, 16'd5,    16'd0,    4'd9, 16'hFFFF, 1'b0, 1'b1};
        vecs[5] = '{ADD, 16'h1234, 16'h4321, 4'd5, 16'h5555, 1'b0, 1'b0};
        vecs[6] = '{SUB, 16'd3,    16'd5,    4'd6, 16'hFFFE, 1'b1, 1'b0};
        vecs[7] = '{MUL, 16'h0100, 16'h0010, 4'hF, 16'h1000, 1'b0, 1'b0};

        #2;
        reset_pulse();
        @(posedge Clk); #1;

        for (int i = 0; i < 8; i++) apply_vec(vecs[i], 1'b0);

        // Back-to-back: one result per cycle.
        for (int i = 0; i < 3; i++) begin
            s_a[i] = vecs[i+1].a; s_b[i] = vecs[i+1].b;
            s_fun[i] = vecs[i+1].fun; s_tag[i] = vecs[i+1].tag;
        end
        start_stream(3);
        res_ready = 1'b1;
        guard = 0;
        while (got_d.size() < 3 && guard < 20) begin drive(); tick(); guard++; end
        cmd_valid = 1'b0; res_ready = 1'b0;
        chk("b2b_count", got_d.size(), 3);
        if (got_d.size() == 3) begin
            chk("b2b_d0", got_d[0], 16'd7);
            chk("b2b_d1", got_d[1], 16'h5F90);
            chk("b2b_d2", got_d[2], 16'd14);
            chk("b2b_t0", got_t[0], 1);
            chk("b2b_t1", got_t[1], 2);
            chk("b2b_t2", got_t[2], 3);
            chk("b2b_gap1", got_c[1] - got_c[0], 1);
            chk("b2b_gap2", got_c[2] - got_c[1], 1);
        end

        // Backpressure: 4 results + 4 queued commands, then drain.
        for (int i = 0; i < 10; i++) begin
            s_a[i] = 16'(i * 100); s_b[i] = 16'd7; s_fun[i] = ADD; s_tag[i] = 4'(i);
        end
        start_stream(10);
        for (int k = 0; k < 20; k++) begin drive(); tick(); end
        chk("bp_accepted", n_acc, 8);
        chk("bp_cmd_ready", cmd_ready, 0);
        chk("bp_enable", Arith_Enable, 0);
        chk("bp_res_valid", res_valid, 1);
        chk("bp_no_pops", got_d.size(), 0);
        res_ready = 1'b1;
        guard = 0;
        while (got_d.size() < 10 && guard < 60) begin drive(); tick(); guard++; end
        res_ready = 1'b0; cmd_valid = 1'b0;
        chk("bp_count", got_d.size(), 10);
        for (int i = 0; i < got_d.size(); i++) begin
            chk("bp_tag", got_t[i], i);
            chk("bp_data", got_d[i], i * 100 + 7);
        end
        chk("bp_busy_end", busy, 0);
        chk("bp_res_valid_end", res_valid, 0);

        // Reset with work queued and in flight.
        for (int i = 0; i < 4; i++) begin
            s_a[i] = 16'(i); s_b[i] = 16'd1; s_fun[i] = ADD; s_tag[i] = 4'(10 + i);
        end
        start_stream(4);
        for (int k = 0; k < 4; k++) begin drive(); tick(); end
        cmd_valid = 1'b0;
        chk("pre_rst_busy", busy, 1);
        reset_pulse();
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (res_valid) seen++;
            @(posedge Clk); #1;
        end
        chk("post_rst_no_result", seen, 0);
        apply_vec(vecs[0], 1'b0);

        // Missing valid flag sets a sticky error; entry is still delivered.
        flag_kill = 1'b1;
        apply_vec(vecs[5], 1'b1);
        flag_kill = 1'b0;
        apply_vec(vecs[1], 1'b1);
        reset_pulse();
        chk("seq_err_cleared", seq_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Upstream issue stage for the 16-bit arithmetic unit. Accepts tagged arithmetic commands over a valid/ready interface and buffers them in a command FIFO. Drives registered operands, function code and enable into the arithmetic unit, tracks its one-cycle registered latency, and collects each result with its tag into a result FIFO. Credit-based issue guarantees the result FIFO never overflows.

Parameters:
WIDTH, 16, operand/result width
TAG_W, 4, command tag width
CMD_DEPTH, 4, command FIFO entries (power of 2, >=2)
RES_DEPTH, 4, result FIFO entries (power of 2, >=4 for full throughput)

Ports:
Clk  in  1  clock, all state on rising edge
RST  in  1  asynchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command FIFO not full
cmd_a  in  WIDTH  operand A
cmd_b  in  WIDTH  operand B
cmd_fun  in  2  00 add, 01 sub, 10 mul, 11 div
cmd_tag  in  TAG_W  returned with result
A  out  WIDTH  to arithmetic unit A
B  out  WIDTH  to arithmetic unit B
Arith_FUN  out  2  to arithmetic unit
Arith_Enable  out  1  to arithmetic unit, high only in issue cycles
Arith_OUT  in  WIDTH  registered result from unit
Carry_OUT  in  1  registered carry from unit
Arith_Flag  in  1  registered valid flag from unit
res_valid  out  1  result FIFO not empty
res_ready  in  1  consumer accepts head result
res_data  out  WIDTH  result (16'hFFFF on divide-by-zero)
res_carry  out  1  carry
res_dz  out  1  divide-by-zero marker
res_tag  out  TAG_W  tag of the originating command
busy  out  1  any command queued, in flight or result pending
seq_err  out  1  sticky: Arith_Flag low when a result was expected

Behaviour:
- Reset (RST high, async): both FIFOs empty, pipeline valids s1_v=s2_v=0, A=B=0, Arith_FUN=0, Arith_Enable=0, seq_err=0. Hence cmd_ready=1 (combinational from count), res_valid=0, busy=0, res_* outputs 0. Reset mid-operation discards every queued and in-flight command. No result emerges after release.
- Command accept: cmd_valid & cmd_ready at an edge pushes {a,b,fun,tag}. cmd_ready = (cmd_count != CMD_DEPTH), with no dependence on same-cycle pop. A full FIFO shows cmd_ready=0 even while popping.
- Issue condition (evaluated each cycle): cmd FIFO non-empty AND (res_count + s1_v + s2_v) < RES_DEPTH. Credits are conservative: a same-cycle result pop does not add credit.
- Issue edge: pop head; register A, B, Arith_FUN and set Arith_Enable=1. Set s1_v=1 and s1_tag, s1_dz = (fun==11 && b==0). When not issuing, Arith_Enable=0 and A/B/Arith_FUN hold their last values.
- Pipeline: s2 <= s1 each edge. The unit registers its result on the edge after issue, so Arith_OUT is valid while s2_v=1.
- Capture: on an edge with s2_v=1, push {dz ? 16'hFFFF : Arith_OUT, Carry_OUT, s2_dz, s2_tag}. If Arith_Flag==0 at that edge, set seq_err=1. The entry is still pushed.
- Result pop: res_valid & res_ready at an edge. Push and pop may occur on the same edge, leaving the count unchanged. The head is shown combinationally from FIFO storage.
- Latency: command accepted at edge N into an empty system gives Arith_Enable high after edge N+1 and res_valid high after edge N+3.
- Throughput: one command per cycle sustained when res_ready=1 and RES_DEPTH>=4.
- busy = cmd_count!=0 | s1_v | s2_v | res_count!=0.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. Counts are log2(DEPTH)+1 bits.

Decomposition:
- Package alu_seq_pkg:
  - FUN constants ADD=2'b00, SUB=2'b01, MUL=2'b10, DIV=2'b11.
  - DZ_RESULT = {WIDTH{1'b1}}.
  - Default WIDTH and TAG_W.
- Sub-module alu_sync_fifo (parameters DATA_W, DEPTH; push/pop/full/empty/count; async active-high reset). Instantiated twice: command FIFO (2*WIDTH+2+TAG_W wide) and result FIFO (WIDTH+2+TAG_W wide).

Test Plan:
- Single add, a=16'hFFFF, b=16'h0001, tag=3, res_ready=1 -> Arith_Enable pulses one cycle; 3 edges after accept: res_valid=1, res_data=16'h0000, res_carry=1, res_tag=3, res_dz=0.
- Back-to-back sub 10-3, mul 300*300, div 100/7 (tags 1,2,3), res_ready=1 -> results 7, 16'h5F90, 14 in order, one per cycle, tags 1,2,3.
- Div 5/0, tag 9 -> res_data=16'hFFFF, res_dz=1, res_tag=9, seq_err=0.
- res_ready=0, push 10 commands -> at most RES_DEPTH results queued, cmd_ready falls after CMD_DEPTH more are buffered, Arith_Enable stops. Then res_ready=1 -> all 10 results drain in order, none lost or duplicated, busy falls after the last pop.
- Assert RST for 1 cycle with 2 commands in flight and 2 queued -> all outputs return to reset values, no res_valid afterwards, next command behaves as in test 1.
- Force Arith_Flag=0 during a capture edge -> seq_err=1 and remains set until RST.
